// File: rtl/alu_operand_loader.sv
// rtl/alu_operand_loader.sv - sequential operand/select loader and result capture for the 4-bit ALU
module alu_operand_loader (
    input  logic       clk,
    input  logic       resetn,
    input  logic [3:0] data_in,
    input  logic       go,
    input  logic       acc_mode,
    input  logic [7:0] alu_result,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_select,
    output logic [7:0] result_out,
    output logic       result_valid,
    output logic [3:0] state,
    output logic [7:0] op_count
);

    typedef enum logic [3:0] {
        LOAD_A       = 4'd0,
        LOAD_A_WAIT  = 4'd1,
        LOAD_B       = 4'd2,
        LOAD_B_WAIT  = 4'd3,
        LOAD_OP      = 4'd4,
        LOAD_OP_WAIT = 4'd5,
        EXEC         = 4'd6,
        DONE         = 4'd7,
        RESTART_WAIT = 4'd8
    } state_t;

    state_t cur_state;
    state_t nxt_state;

    // State register; reset wins over any go level
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cur_state <= LOAD_A;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state: each press is a go-high edge into a WAIT state, release advances
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            LOAD_A:       if (go)  nxt_state = LOAD_A_WAIT;
            LOAD_A_WAIT:  if (!go) nxt_state = LOAD_B;
            LOAD_B:       if (go)  nxt_state = LOAD_B_WAIT;
            LOAD_B_WAIT:  if (!go) nxt_state = LOAD_OP;
            LOAD_OP:      if (go)  nxt_state = LOAD_OP_WAIT;
            LOAD_OP_WAIT: if (!go) nxt_state = EXEC;
            EXEC:                  nxt_state = DONE;
            DONE:         if (go)  nxt_state = RESTART_WAIT;
            RESTART_WAIT: if (!go) nxt_state = LOAD_A;
            default:               nxt_state = LOAD_A;
        endcase
    end

    // Operand capture on the edge leaving each LOAD state; result capture leaving EXEC
    always_ff @(posedge clk) begin
        if (!resetn) begin
            alu_a      <= 4'd0;
            alu_b      <= 4'd0;
            alu_select <= 3'd0;
            result_out <= 8'd0;
            op_count   <= 8'd0;
        end else begin
            if (cur_state == LOAD_A && go) begin
                alu_a <= acc_mode ? result_out[3:0] : data_in;
            end
            if (cur_state == LOAD_B && go) begin
                alu_b <= data_in;
            end
            if (cur_state == LOAD_OP && go) begin
                alu_select <= data_in[2:0];
            end
            if (cur_state == EXEC) begin
                result_out <= alu_result;
                op_count   <= op_count + 8'd1;
            end
        end
    end

    assign result_valid = (cur_state == DONE);
    assign state        = cur_state;

endmodule

// File: tb/tb_alu_operand_loader.sv
// tb/tb_alu_operand_loader.sv - directed self-checking bench for alu_operand_loader
module tb_alu_operand_loader;

    logic       clk;
    logic       resetn;
    logic [3:0] data_in;
    logic       go;
    logic       acc_mode;
    logic [7:0] alu_result;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_select;
    logic [7:0] result_out;
    logic       result_valid;
    logic [3:0] state;
    logic [7:0] op_count;

    int vectors;
    int miscompares;

    alu_operand_loader dut (
        .clk          (clk),
        .resetn       (resetn),
        .data_in      (data_in),
        .go           (go),
        .acc_mode     (acc_mode),
        .alu_result   (alu_result),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_select   (alu_select),
        .result_out   (result_out),
        .result_valid (result_valid),
        .state        (state),
        .op_count     (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ALU stand-in: 0-2 add, 3 {xor,or}, 4 reduction-or flag, 5 concat, 6-7 zero
    always_comb begin
        alu_result = 8'h00;
        case (alu_select)
            3'd0, 3'd1, 3'd2: alu_result = {4'h0, alu_a} + {4'h0, alu_b};
            3'd3:             alu_result = {alu_a ^ alu_b, alu_a | alu_b};
            3'd4:             alu_result = {7'd0, |{alu_a, alu_b}};
            3'd5:             alu_result = {alu_a, alu_b};
            default:          alu_result = 8'h00;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic press(input logic [3:0] value, input logic acc);
        data_in  = value;
        acc_mode = acc;
        go       = 1'b1;
        tick();
        go       = 1'b0;
        acc_mode = 1'b0;
        tick();
    endtask

    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        press(a, 1'b0);
        press(b, 1'b0);
        press(op, 1'b0);
        tick();
    endtask

    task automatic do_reset(input int cycles);
        resetn = 1'b0;
        for (int i = 0; i < cycles; i++) tick();
        resetn = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        resetn      = 1'b0;
        data_in     = 4'd0;
        go          = 1'b0;
        acc_mode    = 1'b0;
        #1;

        // Reset state
        do_reset(2);
        check("rst_state", {4'd0, state}, 8'd0);
        check("rst_a", {4'd0, alu_a}, 8'd0);
        check("rst_b", {4'd0, alu_b}, 8'd0);
        check("rst_sel", {5'd0, alu_select}, 8'd0);
        check("rst_result", result_out, 8'd0);
        check("rst_valid", {7'd0, result_valid}, 8'd0);
        check("rst_count", op_count, 8'd0);

        // Basic add 3 + 5 with select 2
        run_op(4'd3, 4'd5, 4'd2);
        check("add_state", {4'd0, state}, 8'd7);
        check("add_result", result_out, 8'h08);
        check("add_valid", {7'd0, result_valid}, 8'd1);
        check("add_count", op_count, 8'd1);

        // Restart press: through RESTART_WAIT back to LOAD_A, operands held
        go = 1'b1;
        tick();
        check("restart_wait_state", {4'd0, state}, 8'd8);
        check("restart_wait_valid", {7'd0, result_valid}, 8'd0);
        check("restart_wait_a", {4'd0, alu_a}, 8'd3);
        go = 1'b0;
        tick();
        check("restart_state", {4'd0, state}, 8'd0);
        check("restart_sel_held", {5'd0, alu_select}, 8'd2);

        // Accumulate: A takes result_out[3:0]=8, data_in=F ignored; 8+1
        press(4'hF, 1'b1);
        check("acc_a", {4'd0, alu_a}, 8'd8);
        press(4'd1, 1'b0);
        press(4'd0, 1'b0);
        tick();
        check("acc_result", result_out, 8'h09);
        check("acc_count", op_count, 8'd2);
        go = 1'b1; tick(); go = 1'b0; tick();

        // Held go in LOAD_A: one capture, data changes ignored
        data_in = 4'd9;
        go      = 1'b1;
        tick();
        check("held_a_first", {4'd0, alu_a}, 8'd9);
        for (int i = 0; i < 19; i++) begin
            if (i == 10) data_in = 4'd4;
            tick();
            check("held_state", {4'd0, state}, 8'd1);
        end
        check("held_a_last", {4'd0, alu_a}, 8'd9);
        go = 1'b0;
        tick();
        check("held_release_state", {4'd0, state}, 8'd2);
        press(4'd5, 1'b0);
        press(4'd0, 1'b0);
        tick();
        check("held_result", result_out, 8'h0E);
        check("held_count", op_count, 8'd3);
        go = 1'b1; tick(); go = 1'b0; tick();

        // Concatenation, then select 7 returns zero and still counts
        run_op(4'hF, 4'hA, 4'd5);
        check("concat_result", result_out, 8'hFA);
        check("concat_count", op_count, 8'd4);
        go = 1'b1; tick(); go = 1'b0; tick();
        run_op(4'hF, 4'hA, 4'd7);
        check("op7_sel", {5'd0, alu_select}, 8'd7);
        check("op7_result", result_out, 8'h00);
        check("op7_count", op_count, 8'd5);
        go = 1'b1; tick(); go = 1'b0; tick();

        // Select code ignores data_in[3]: 0xB -> 3, {A^B, A|B}
        run_op(4'h6, 4'h3, 4'hB);
        check("op3_sel", {5'd0, alu_select}, 8'd3);
        check("op3_result", result_out, 8'h57);
        go = 1'b1; tick(); go = 1'b0; tick();

        // Reset in LOAD_B_WAIT with go held
        press(4'd2, 1'b0);
        data_in = 4'd6;
        go      = 1'b1;
        tick();
        check("midrst_pre_state", {4'd0, state}, 8'd3);
        check("midrst_pre_b", {4'd0, alu_b}, 8'd6);
        resetn   = 1'b0;
        acc_mode = 1'b1;
        data_in  = 4'hF;
        tick();
        check("midrst_state", {4'd0, state}, 8'd0);
        check("midrst_a", {4'd0, alu_a}, 8'd0);
        check("midrst_b", {4'd0, alu_b}, 8'd0);
        check("midrst_result", result_out, 8'd0);
        check("midrst_count", op_count, 8'd0);
        check("midrst_valid", {7'd0, result_valid}, 8'd0);
        resetn = 1'b1;
        tick();
        check("post_rst_go_state", {4'd0, state}, 8'd1);
        check("post_rst_acc_a", {4'd0, alu_a}, 8'd0);
        go       = 1'b0;
        acc_mode = 1'b0;
        tick();
        check("post_rst_release", {4'd0, state}, 8'd2);
        press(4'd3, 1'b0);
        press(4'd0, 1'b0);
        tick();
        check("post_rst_result", result_out, 8'h03);
        check("post_rst_count", op_count, 8'd1);
        go = 1'b1; tick(); go = 1'b0; tick();

        // Wrap: 256 operations from a fresh reset
        do_reset(1);
        for (int i = 0; i < 255; i++) begin
            run_op(4'd1, 4'd1, 4'd0);
            go = 1'b1; tick(); go = 1'b0; tick();
        end
        check("wrap_pre_count", op_count, 8'd255);
        run_op(4'd1, 4'd1, 4'd0);
        check("wrap_count", op_count, 8'd0);
        check("wrap_result", result_out, 8'h02);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
